// File: rtl/muldiv_arbiter.sv
// muldiv_arbiter: round-robin front end for one shared iterative mul/div engine.
// Two requesters compete for the engine. Divide special cases are answered
// locally without starting the engine. A watchdog bounds the time spent
// waiting for the engine, and results go back on per-requester handshakes.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no transaction; grant is offered to one requester
//   ISSUE   | operands latched; eng_start pulses for this one cycle
//   WAIT    | engine running; watchdog counting toward MAX_LATENCY
//   RESPOND | result/err held on rsp[owner] until the requester takes it
module muldiv_arbiter #(
    parameter int unsigned MAX_LATENCY = 66
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_data,
    output logic        rsp0_err,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_data,
    output logic        rsp1_err,
    output logic        eng_start,
    output logic [2:0]  eng_op,
    output logic [31:0] eng_a,
    output logic [31:0] eng_b,
    input  logic        eng_done,
    input  logic [31:0] eng_result,
    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RESPOND = 2'd3
    } state_t;

    localparam int unsigned CW = $clog2(MAX_LATENCY + 1);
    // Last WAIT cycle: the counter would reach MAX_LATENCY on the next edge.
    localparam logic [CW-1:0] WD_LAST = CW'(MAX_LATENCY - 1);

    state_t        state_q, state_d;
    logic          rr_ptr_q, rr_ptr_d;
    logic          owner_q, owner_d;
    logic [2:0]    op_q, op_d;
    logic [31:0]   a_q, a_d;
    logic [31:0]   b_q, b_d;
    logic [CW-1:0] wd_cnt_q, wd_cnt_d;
    logic [31:0]   data_q, data_d;
    logic          err_q, err_d;
    logic          eng_start_q, eng_start_d;
    logic          rsp0_valid_q, rsp0_valid_d;
    logic          rsp1_valid_q, rsp1_valid_d;
    logic          busy_q, busy_d;

    logic          grant;
    logic          accept;
    logic [2:0]    sel_op;
    logic [31:0]   sel_a;
    logic [31:0]   sel_b;
    logic          is_special;
    logic [31:0]   special_val;

    // Round-robin grant: rr_ptr only breaks ties when both requesters are valid.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = rr_ptr_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready = (state_q == S_IDLE) && !grant;
    assign req1_ready = (state_q == S_IDLE) && grant;
    assign accept     = (state_q == S_IDLE) && (grant ? req1_valid : req0_valid);

    assign sel_op = grant ? req1_op : req0_op;
    assign sel_a  = grant ? req1_a  : req0_a;
    assign sel_b  = grant ? req1_b  : req0_b;

    // Divide-by-zero and signed overflow are answered without the engine.
    // op[2] marks the divide group; op[1] selects remainder over quotient.
    always_comb begin
        is_special  = 1'b0;
        special_val = 32'h0;
        if (sel_op[2] && (sel_b == 32'h0)) begin
            is_special  = 1'b1;
            special_val = sel_op[1] ? sel_a : 32'hFFFF_FFFF;
        end else if (sel_op[2] && !sel_op[0] &&
                     (sel_a == 32'h8000_0000) && (sel_b == 32'hFFFF_FFFF)) begin
            is_special  = 1'b1;
            special_val = sel_op[1] ? 32'h0 : 32'h8000_0000;
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        wd_cnt_d = wd_cnt_q;
        data_d   = data_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d    = sel_op;
                    a_d     = sel_a;
                    b_d     = sel_b;
                    owner_d = grant;
                    if (is_special) begin
                        data_d  = special_val;
                        err_d   = 1'b0;
                        state_d = S_RESPOND;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                wd_cnt_d = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                // A done arriving on the watchdog's last cycle still wins.
                if (eng_done) begin
                    data_d  = eng_result;
                    err_d   = 1'b0;
                    state_d = S_RESPOND;
                end else if (wd_cnt_q == WD_LAST) begin
                    data_d  = 32'h0;
                    err_d   = 1'b1;
                    state_d = S_RESPOND;
                end else begin
                    wd_cnt_d = wd_cnt_q + CW'(1);
                end
            end
            S_RESPOND: begin
                if (owner_q ? rsp1_ready : rsp0_ready) begin
                    rr_ptr_d = ~owner_q;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        eng_start_d  = (state_d == S_ISSUE);
        rsp0_valid_d = (state_d == S_RESPOND) && !owner_d;
        rsp1_valid_d = (state_d == S_RESPOND) && owner_d;
        busy_d       = (state_d != S_IDLE);
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= 1'b0;
            owner_q      <= 1'b0;
            op_q         <= 3'd0;
            a_q          <= 32'h0;
            b_q          <= 32'h0;
            wd_cnt_q     <= '0;
            data_q       <= 32'h0;
            err_q        <= 1'b0;
            eng_start_q  <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            wd_cnt_q     <= wd_cnt_d;
            data_q       <= data_d;
            err_q        <= err_d;
            eng_start_q  <= eng_start_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign eng_start  = eng_start_q;
    assign eng_op     = op_q;
    assign eng_a      = a_q;
    assign eng_b      = b_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_data  = data_q;
    assign rsp1_data  = data_q;
    assign rsp0_err   = err_q;
    assign rsp1_err   = err_q;
    assign busy       = busy_q;
    assign owner      = owner_q;

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Directed bench for muldiv_arbiter: a vector table for single transactions
// plus hand-written sequences for contention, backpressure, watchdog and reset.
module tb_muldiv_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready, rsp1_ready;
    logic [31:0] rsp0_data, rsp1_data;
    logic        rsp0_err, rsp1_err;
    logic        eng_start;
    logic [2:0]  eng_op;
    logic [31:0] eng_a, eng_b;
    logic        eng_done;
    logic [31:0] eng_result;
    logic        busy, owner;

    int n_vec = 0;
    int n_bad = 0;
    int n_start = 0;

    always #5 clk = ~clk;

    muldiv_arbiter #(.MAX_LATENCY(66)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .rsp1_err(rsp1_err),
        .eng_start(eng_start), .eng_op(eng_op), .eng_a(eng_a), .eng_b(eng_b),
        .eng_done(eng_done), .eng_result(eng_result),
        .busy(busy), .owner(owner)
    );

    // Count cycles in which the start pulse is high.
    always @(posedge clk) if (eng_start) n_start++;

    typedef struct {
        bit          who;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] eng_res;
        logic [31:0] exp;
        bit          special;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input bit who, input logic v, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        if (who) begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end
    endtask

    // Called at the negedge of the ISSUE cycle; done is raised lat cycles later.
    task automatic engine_done(input int lat, input logic [31:0] res);
        repeat (lat) @(negedge clk);
        chk("pre_done_valid", {31'd0, rsp0_valid | rsp1_valid}, 32'd0);
        eng_done = 1'b1;
        eng_result = res;
        @(negedge clk);
        eng_done = 1'b0;
    endtask

    task automatic take_rsp(input bit who);
        if (who) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        chk("rsp_cleared", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    endtask

    task automatic run_txn(input vec_t v);
        int s0;
        s0 = n_start;
        @(negedge clk);
        set_req(v.who, 1'b1, v.op, v.a, v.b);
        #1;
        chk("req_ready", {31'd0, v.who ? req1_ready : req0_ready}, 32'd1);
        @(negedge clk);
        set_req(v.who, 1'b0, 3'd0, 32'd0, 32'd0);
        if (v.special) begin
            chk("special_valid_t1", {31'd0, v.who ? rsp1_valid : rsp0_valid}, 32'd1);
            chk("special_no_start", {31'd0, eng_start}, 32'd0);
        end else begin
            chk("eng_start", {31'd0, eng_start}, 32'd1);
            chk("eng_op", {29'd0, eng_op}, {29'd0, v.op});
            chk("eng_a", eng_a, v.a);
            chk("eng_b", eng_b, v.b);
            engine_done(v.lat, v.eng_res);
            chk("rsp_valid", {31'd0, v.who ? rsp1_valid : rsp0_valid}, 32'd1);
        end
        chk("rsp_data", v.who ? rsp1_data : rsp0_data, v.exp);
        chk("rsp_err", {31'd0, v.who ? rsp1_err : rsp0_err}, 32'd0);
        chk("other_valid", {31'd0, v.who ? rsp0_valid : rsp1_valid}, 32'd0);
        chk("owner", {31'd0, owner}, {31'd0, v.who});
        take_rsp(v.who);
        chk("start_pulses", n_start - s0, v.special ? 32'd0 : 32'd1);
        chk("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tmp;
        int s0;
        logic [31:0] held;

        //          who op    a             b             lat eng_res       exp           special
        vecs[0]  = '{0, 3'd0, 32'd7,        32'd6,        32, 32'd42,       32'd42,       0};
        vecs[1]  = '{0, 3'd4, 32'd5,        32'd0,        0,  32'd0,        32'hFFFFFFFF, 1};
        vecs[2]  = '{0, 3'd6, 32'd5,        32'd0,        0,  32'd0,        32'd5,        1};
        vecs[3]  = '{1, 3'd4, 32'h80000000, 32'hFFFFFFFF, 0,  32'd0,        32'h80000000, 1};
        vecs[4]  = '{1, 3'd6, 32'h80000000, 32'hFFFFFFFF, 0,  32'd0,        32'd0,        1};
        vecs[5]  = '{1, 3'd5, 32'd9,        32'd0,        0,  32'd0,        32'hFFFFFFFF, 1};
        vecs[6]  = '{0, 3'd7, 32'd12345,    32'd0,        0,  32'd0,        32'd12345,    1};
        vecs[7]  = '{1, 3'd4, 32'h80000000, 32'd1,        5,  32'h80000000, 32'h80000000, 0};
        vecs[8]  = '{0, 3'd5, 32'h80000000, 32'hFFFFFFFF, 1,  32'd0,        32'd0,        0};
        vecs[9]  = '{1, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 2,  32'hFFFFFFFE, 32'hFFFFFFFE, 0};
        vecs[10] = '{1, 3'd0, 32'd3,        32'd4,        3,  32'd12,       32'd12,       0};

        reset = 1'b0;
        req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
        req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
        rsp0_ready = 0; rsp1_ready = 0;
        eng_done = 0; eng_result = 0;

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_owner", {31'd0, owner}, 32'd0);
        chk("rst_start", {31'd0, eng_start}, 32'd0);
        chk("rst_eng_op", {29'd0, eng_op}, 32'd0);
        chk("rst_eng_ab", eng_a | eng_b, 32'd0);
        chk("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        chk("rst_rsp_data", rsp0_data | rsp1_data, 32'd0);
        chk("rst_rsp_err", {30'd0, rsp1_err, rsp0_err}, 32'd0);

        // Contention at reset exit: req0 first, then req1 wins the tie.
        s0 = n_start;
        set_req(0, 1'b1, 3'd5, 32'd100, 32'd7);
        set_req(1, 1'b1, 3'd7, 32'd100, 32'd7);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("cont_ready0", {31'd0, req0_ready}, 32'd1);
        chk("cont_ready1", {31'd0, req1_ready}, 32'd0);
        @(negedge clk);
        set_req(0, 1'b0, 3'd0, 32'd0, 32'd0);
        chk("cont_start0", {31'd0, eng_start}, 32'd1);
        chk("cont_op0", {29'd0, eng_op}, 32'd5);
        chk("cont_owner0", {31'd0, owner}, 32'd0);
        chk("cont_ready1_busy", {31'd0, req1_ready}, 32'd0);
        engine_done(4, 32'd14);
        chk("cont_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
        chk("cont_rsp0_data", rsp0_data, 32'd14);
        take_rsp(0);
        set_req(0, 1'b1, 3'd5, 32'd100, 32'd7);
        #1;
        chk("rr_ready1", {31'd0, req1_ready}, 32'd1);
        chk("rr_ready0", {31'd0, req0_ready}, 32'd0);
        @(negedge clk);
        set_req(0, 1'b0, 3'd0, 32'd0, 32'd0);
        set_req(1, 1'b0, 3'd0, 32'd0, 32'd0);
        chk("cont_owner1", {31'd0, owner}, 32'd1);
        chk("cont_op1", {29'd0, eng_op}, 32'd7);
        engine_done(6, 32'd2);
        chk("cont_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
        chk("cont_rsp1_data", rsp1_data, 32'd2);
        chk("cont_rsp0_quiet", {31'd0, rsp0_valid}, 32'd0);
        take_rsp(1);
        chk("cont_two_starts", n_start - s0, 32'd2);

        // Table of single transactions.
        for (int i = 0; i < 10; i++) run_txn(vecs[i]);

        // Backpressure on rsp1 while req0 waits.
        @(negedge clk);
        set_req(1, 1'b1, 3'd0, 32'd3, 32'd5);
        @(negedge clk);
        set_req(1, 1'b0, 3'd0, 32'd0, 32'd0);
        engine_done(2, 32'd15);
        held = rsp1_data;
        chk("bp_data_first", held, 32'd15);
        set_req(0, 1'b1, 3'd0, 32'd2, 32'd2);
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("bp_req0_ready", {31'd0, req0_ready}, 32'd0);
            chk("bp_data_held", rsp1_data, 32'd15);
            chk("bp_valid_held", {31'd0, rsp1_valid}, 32'd1);
            @(negedge clk);
        end
        rsp1_ready = 1'b1;
        @(negedge clk);
        rsp1_ready = 1'b0;
        chk("bp_rsp1_cleared", {31'd0, rsp1_valid}, 32'd0);
        #1;
        chk("bp_req0_ready_after", {31'd0, req0_ready}, 32'd1);
        @(negedge clk);
        set_req(0, 1'b0, 3'd0, 32'd0, 32'd0);
        chk("bp_req0_start", {31'd0, eng_start}, 32'd1);
        chk("bp_req0_a", eng_a, 32'd2);
        engine_done(1, 32'd4);
        chk("bp_req0_data", rsp0_data, 32'd4);
        take_rsp(0);

        // Watchdog: engine never answers.
        @(negedge clk);
        set_req(0, 1'b1, 3'd0, 32'd11, 32'd13);
        @(negedge clk);
        set_req(0, 1'b0, 3'd0, 32'd0, 32'd0);
        chk("wd_start", {31'd0, eng_start}, 32'd1);
        repeat (66) @(negedge clk);
        chk("wd_not_yet", {31'd0, rsp0_valid}, 32'd0);
        @(negedge clk);
        chk("wd_valid", {31'd0, rsp0_valid}, 32'd1);
        chk("wd_err", {31'd0, rsp0_err}, 32'd1);
        chk("wd_data", rsp0_data, 32'd0);
        eng_done = 1'b1; eng_result = 32'hDEADBEEF;
        @(negedge clk);
        eng_done = 1'b0;
        chk("wd_late_done_data", rsp0_data, 32'd0);
        chk("wd_late_done_err", {31'd0, rsp0_err}, 32'd1);
        take_rsp(0);
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
        chk("wd_idle_done_busy", {31'd0, busy}, 32'd0);
        chk("wd_idle_done_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        run_txn(vecs[10]);

        // Reset during WAIT; rr_ptr is 1 before the abort.
        tmp = vecs[0];
        run_txn(tmp);
        @(negedge clk);
        set_req(1, 1'b1, 3'd0, 32'd6, 32'd7);
        @(negedge clk);
        set_req(1, 1'b0, 3'd0, 32'd0, 32'd0);
        chk("rw_owner1", {31'd0, owner}, 32'd1);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rw_busy", {31'd0, busy}, 32'd0);
        chk("rw_owner", {31'd0, owner}, 32'd0);
        chk("rw_eng", {29'd0, eng_op} | eng_a | eng_b, 32'd0);
        chk("rw_rsp", {29'd0, rsp1_valid, rsp0_valid, rsp0_err} | rsp0_data, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        eng_done = 1'b1; eng_result = 32'd42;
        @(negedge clk);
        eng_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rw_stray_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        chk("rw_stray_busy", {31'd0, busy}, 32'd0);
        set_req(0, 1'b1, 3'd0, 32'd1, 32'd1);
        set_req(1, 1'b1, 3'd0, 32'd1, 32'd1);
        #1;
        chk("rw_rr_ready0", {31'd0, req0_ready}, 32'd1);
        chk("rw_rr_ready1", {31'd0, req1_ready}, 32'd0);
        set_req(0, 1'b0, 3'd0, 32'd0, 32'd0);
        set_req(1, 1'b0, 3'd0, 32'd0, 32'd0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
